instruction_fetch: RTL and testbench
====================================

Name: instruction_fetch

Overview:
- Requester side of the instruction-memory read interface.
- Holds the fetch program counter and drives read_en/addr into the synchronous ROM, which has 1-cycle read latency.
- Tracks which returned word is valid and presents it to decode with a valid/ready handshake.
- Handles branch redirects and downstream stalls without losing or duplicating instructions.

Parameters:
- ADDR_WIDTH, 16, width of instruction address / PC.
- DATA_WIDTH, 16, width of instruction word.
- RESET_PC, 0, first address fetched after reset.

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst  input  1  synchronous, active-high reset.
- fetch_en  input  1  permits sequential fetch; low = no new sequential reads.
- redirect_en  input  1  branch/jump redirect request, single-cycle pulse.
- redirect_pc  input  ADDR_WIDTH  redirect target, sampled when redirect_en=1.
- mem_read_en  output  1  read enable to instruction memory.
- mem_addr  output  ADDR_WIDTH  address to instruction memory.
- mem_instruct  input  DATA_WIDTH  registered memory data; valid the cycle after a read; holds while mem_read_en=0.
- instr_valid  output  1  instr/instr_pc hold a valid instruction.
- instr  output  DATA_WIDTH  instruction to decode (mem_instruct passthrough).
- instr_pc  output  ADDR_WIDTH  address of instr.
- decode_ready  input  1  decode accepts instr this cycle.

Behaviour:
- State registers: fetch_pc (next sequential address), resp_valid, resp_pc.
- Outputs: instr_valid=resp_valid, instr=mem_instruct, instr_pc=resp_pc.
- Transfer occurs when instr_valid & decode_ready.
- Reset (rst=1): fetch_pc<=RESET_PC, resp_valid<=0, resp_pc<=0, mem_read_en=0, mem_addr=RESET_PC. redirect_en and fetch_en are ignored. Reset mid-stream drops any valid instruction; the next cycle has instr_valid=0.
- Per-cycle priority when rst=0:
  1. redirect_en=1: mem_read_en=1, mem_addr=redirect_pc (combinational), fetch_pc<=redirect_pc+1, resp_valid<=1, resp_pc<=redirect_pc. Any currently held instruction is discarded, whether or not decode_ready. Honoured even when fetch_en=0. Zero-bubble: the target instruction is valid the next cycle.
  2. Else advance = fetch_en & (~resp_valid | decode_ready): mem_read_en=1, mem_addr=fetch_pc, fetch_pc<=fetch_pc+1, resp_valid<=1, resp_pc<=fetch_pc.
  3. Else: mem_read_en=0, mem_addr=fetch_pc. If resp_valid & decode_ready then resp_valid<=0; otherwise hold.
- Stall (instr_valid=1, decode_ready=0): mem_read_en=0, so memory output and instr hold stable; instr_pc stable.
- Steady state (fetch_en=1, decode_ready=1): one instruction per cycle, consecutive PCs.
- fetch_pc+1 is modulo 2^ADDR_WIDTH; 0xFFFF wraps to 0x0000 with no flag.
- redirect_pc+1 wraps identically.
- Latency: first instr_valid occurs 2 cycles after rst deasserts with fetch_en=1 (issue cycle, then data cycle).
- No instruction is presented twice; none is skipped except those squashed by a redirect.

Optional Feature:
- Macro FETCH_PERF_EN.
- When defined, adds outputs perf_fetched (32 bits) and perf_stall (32 bits), reset to 0:
  - perf_fetched increments on each handshake transfer.
  - perf_stall increments each cycle with instr_valid=1 & decode_ready=0.
  - Both counters saturate at 0xFFFFFFFF.
- When undefined, these ports and counters do not exist; core behaviour is identical.

Test Plan:
- Reset release, fetch_en=1, decode_ready=1, ROM[i]=i^0xA5A5 -> cycle 2: instr_valid=1, instr_pc=0x0000, instr=0xA5A5; then PCs 1,2,3 on consecutive cycles.
- Stall: decode_ready=0 for 3 cycles while instr_pc=0x0004 -> mem_read_en=0, instr/instr_pc held 3 cycles; on release, 0x0004 transfers once, then 0x0005 follows.
- Redirect: redirect_en=1, redirect_pc=0x0100 while instr_pc=0x0007 and stalled -> next cycle instr_pc=0x0100, instr=ROM[0x100]; 0x0007 never transfers; then 0x0101.
- Wrap: redirect to 0xFFFE, free-run -> PC sequence 0xFFFE, 0xFFFF, 0x0000, 0x0001.
- fetch_en=0 with valid instr and decode_ready=1 -> transfers, then instr_valid=0, mem_read_en=0; redirect_en to 0x0020 while fetch_en=0 -> 0x0020 presented, then idle.
- rst asserted mid-stream at instr_pc=0x0030 -> next cycle instr_valid=0; after release fetch restarts at RESET_PC; with FETCH_PERF_EN, perf counters read 0.

Source files
------------

// File: rtl/instruction_fetch.sv
// Instruction fetch front end: drives a 1-cycle-latency instruction ROM and
// hands returned words to decode over valid/ready. Optional FETCH_PERF_EN adds perf counters.
module instruction_fetch #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 16,
  parameter int RESET_PC   = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fetch_en,
  input  logic                  redirect_en,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic                  mem_read_en,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_instruct,
  output logic                  instr_valid,
  output logic [DATA_WIDTH-1:0] instr,
  output logic [ADDR_WIDTH-1:0] instr_pc,
  input  logic                  decode_ready
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]           perf_fetched,
  output logic [31:0]           perf_stall
`endif
);

  localparam logic [ADDR_WIDTH-1:0] RESET_ADDR = ADDR_WIDTH'(RESET_PC);
  localparam logic [ADDR_WIDTH-1:0] ONE        = ADDR_WIDTH'(1);

  logic [ADDR_WIDTH-1:0] fetch_pc;
  logic [ADDR_WIDTH-1:0] resp_pc;
  logic                  resp_valid;
  logic                  advance;
  logic                  transfer;

  assign instr_valid = resp_valid;
  assign instr       = mem_instruct;
  assign instr_pc    = resp_pc;
  assign transfer    = resp_valid & decode_ready;

  // Read request is combinational so a redirect target is issued the same
  // cycle it arrives and returns valid on the next one.
  always_comb begin
    advance     = fetch_en & (~resp_valid | decode_ready);
    mem_read_en = 1'b0;
    mem_addr    = fetch_pc;
    if (rst) begin
      mem_addr = RESET_ADDR;
    end else if (redirect_en) begin
      mem_read_en = 1'b1;
      mem_addr    = redirect_pc;
    end else if (advance) begin
      mem_read_en = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc   <= RESET_ADDR;
      resp_valid <= 1'b0;
      resp_pc    <= '0;
    end else if (redirect_en) begin
      fetch_pc   <= redirect_pc + ONE;
      resp_valid <= 1'b1;
      resp_pc    <= redirect_pc;
    end else if (advance) begin
      fetch_pc   <= fetch_pc + ONE;
      resp_valid <= 1'b1;
      resp_pc    <= fetch_pc;
    end else if (transfer) begin
      resp_valid <= 1'b0;
    end
  end

`ifdef FETCH_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetched <= '0;
      perf_stall   <= '0;
    end else begin
      if (transfer && perf_fetched != '1)
        perf_fetched <= perf_fetched + 32'd1;
      if (resp_valid && !decode_ready && perf_stall != '1)
        perf_stall <= perf_stall + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch with a behavioural ROM (word = addr ^ 0xA5A5)
// and a scoreboard of expected decode transfers.
module tb_instruction_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        fetch_en;
  logic        redirect_en;
  logic [15:0] redirect_pc;
  logic        mem_read_en;
  logic [15:0] mem_addr;
  logic [15:0] mem_instruct = '0;
  logic        instr_valid;
  logic [15:0] instr;
  logic [15:0] instr_pc;
  logic        decode_ready;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_stall;
`endif

  int tests = 0;
  int fails = 0;
  logic [15:0] exp_q[$];

  always #5 clk = ~clk;

  instruction_fetch #(.ADDR_WIDTH(16), .DATA_WIDTH(16), .RESET_PC(0)) dut (
    .clk          (clk),
    .rst          (rst),
    .fetch_en     (fetch_en),
    .redirect_en  (redirect_en),
    .redirect_pc  (redirect_pc),
    .mem_read_en  (mem_read_en),
    .mem_addr     (mem_addr),
    .mem_instruct (mem_instruct),
    .instr_valid  (instr_valid),
    .instr        (instr),
    .instr_pc     (instr_pc),
    .decode_ready (decode_ready)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetched (perf_fetched),
    .perf_stall   (perf_stall)
`endif
  );

  // Synchronous ROM, one-cycle latency, output holds while not read.
  always @(posedge clk)
    if (mem_read_en) mem_instruct <= mem_addr ^ 16'hA5A5;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_instr(input string tag, input logic [15:0] pc);
    chk({tag, "_valid"}, {31'd0, instr_valid}, 32'd1);
    chk({tag, "_pc"}, {16'd0, instr_pc}, {16'd0, pc});
    chk({tag, "_instr"}, {16'd0, instr}, {16'd0, pc ^ 16'hA5A5});
  endtask

  // Every handshake must match the next expected PC in order.
  always @(negedge clk) begin
    if (instr_valid === 1'b1 && decode_ready === 1'b1) begin
      tests++;
      assert (exp_q.size() != 0)
      else begin
        fails++;
        $error("FAIL sb_extra: observed transfer pc %0h expected none", instr_pc);
      end
      if (exp_q.size() != 0) begin
        logic [15:0] e;
        e = exp_q.pop_front();
        chk("sb_pc", {16'd0, instr_pc}, {16'd0, e});
        chk("sb_instr", {16'd0, instr}, {16'd0, e ^ 16'hA5A5});
      end
    end
  end

  initial begin
    #100000;
    $error("FAIL watchdog: observed timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [15:0] wrap_pcs [4];
    wrap_pcs = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};
    rst = 1'b1; fetch_en = 1'b0; redirect_en = 1'b0; redirect_pc = '0; decode_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", {31'd0, instr_valid}, 32'd0);
    chk("rst_rd_en", {31'd0, mem_read_en}, 32'd0);
    chk("rst_addr", {16'd0, mem_addr}, 32'd0);

    // Release reset and free-run
    nxt();
    rst = 1'b0; fetch_en = 1'b1; decode_ready = 1'b1;
    for (int i = 0; i < 7; i++) exp_q.push_back(16'(i));
    @(negedge clk);
    chk("issue_valid", {31'd0, instr_valid}, 32'd0);
    chk("issue_rd_en", {31'd0, mem_read_en}, 32'd1);
    chk("issue_addr", {16'd0, mem_addr}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      nxt();
      @(negedge clk);
      chk_instr("seq", 16'(i));
    end

    // Stall on PC 4 for three cycles
    nxt();
    decode_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk_instr("stall", 16'h0004);
      chk("stall_rd_en", {31'd0, mem_read_en}, 32'd0);
      nxt();
    end
    decode_ready = 1'b1;
    @(negedge clk);
    chk_instr("release", 16'h0004);
    chk("release_addr", {16'd0, mem_addr}, 32'h5);
    nxt();
    nxt();
    nxt();

    // Redirect while PC 7 is stalled; 7 must never transfer
    decode_ready = 1'b0; redirect_en = 1'b1; redirect_pc = 16'h0100;
    exp_q.push_back(16'h0100); exp_q.push_back(16'h0101);
    @(negedge clk);
    chk_instr("pre_redir", 16'h0007);
    chk("redir_rd_en", {31'd0, mem_read_en}, 32'd1);
    chk("redir_addr", {16'd0, mem_addr}, 32'h0100);
    nxt();
    redirect_en = 1'b0; decode_ready = 1'b1;
    @(negedge clk);
    chk_instr("redir_tgt", 16'h0100);

    // Redirect near the top of the address space and wrap
    nxt();
    redirect_en = 1'b1; redirect_pc = 16'hFFFE;
    for (int i = 0; i < 4; i++) exp_q.push_back(wrap_pcs[i]);
    exp_q.push_back(16'h0002);
    @(negedge clk);
    chk_instr("redir_tgt_next", 16'h0101);
    for (int i = 0; i < 4; i++) begin
      nxt();
      redirect_en = 1'b0;
      @(negedge clk);
      chk_instr("wrap", wrap_pcs[i]);
    end

    // fetch_en low: drain, go idle, then redirect from idle
    nxt();
    fetch_en = 1'b0;
    @(negedge clk);
    chk_instr("drain", 16'h0002);
    chk("drain_rd_en", {31'd0, mem_read_en}, 32'd0);
    nxt();
    @(negedge clk);
    chk("idle_valid", {31'd0, instr_valid}, 32'd0);
    chk("idle_rd_en", {31'd0, mem_read_en}, 32'd0);
    nxt();
    redirect_en = 1'b1; redirect_pc = 16'h0020;
    exp_q.push_back(16'h0020);
    @(negedge clk);
    chk("idle_redir_rd_en", {31'd0, mem_read_en}, 32'd1);
    chk("idle_redir_addr", {16'd0, mem_addr}, 32'h0020);
    nxt();
    redirect_en = 1'b0;
    @(negedge clk);
    chk_instr("idle_redir_tgt", 16'h0020);
    nxt();
    @(negedge clk);
    chk("idle2_valid", {31'd0, instr_valid}, 32'd0);
    chk("idle2_rd_en", {31'd0, mem_read_en}, 32'd0);
    chk("idle2_addr", {16'd0, mem_addr}, 32'h0021);

    // Reset mid-stream while 0x0030 is held
    nxt();
    fetch_en = 1'b1; redirect_en = 1'b1; redirect_pc = 16'h0030;
    @(negedge clk);
    chk("pre_rst_addr", {16'd0, mem_addr}, 32'h0030);
    nxt();
    redirect_en = 1'b0; decode_ready = 1'b0; rst = 1'b1;
    @(negedge clk);
    chk_instr("pre_rst_held", 16'h0030);
    chk("rst_mid_rd_en", {31'd0, mem_read_en}, 32'd0);
    chk("rst_mid_addr", {16'd0, mem_addr}, 32'd0);
    nxt();
    rst = 1'b0; decode_ready = 1'b1;
    exp_q.push_back(16'h0000); exp_q.push_back(16'h0001);
    @(negedge clk);
    chk("post_rst_valid", {31'd0, instr_valid}, 32'd0);
    chk("post_rst_rd_en", {31'd0, mem_read_en}, 32'd1);
    chk("post_rst_addr", {16'd0, mem_addr}, 32'd0);
`ifdef FETCH_PERF_EN
    chk("perf_fetched_rst", perf_fetched, 32'd0);
    chk("perf_stall_rst", perf_stall, 32'd0);
`endif
    nxt();
    @(negedge clk);
    chk_instr("restart", 16'h0000);
    nxt();
    fetch_en = 1'b0;
    @(negedge clk);
    chk_instr("restart", 16'h0001);
    nxt();
    @(negedge clk);
    chk("end_valid", {31'd0, instr_valid}, 32'd0);
    chk("sb_drained", exp_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
